// File: rtl/eth_tx_sched_if.sv
// Bundle between the TX scheduler and its neighbours: eth_recv type pulses, ARP/UDP byte sources, framer output.
// slave is the scheduler's view; master is the view of whatever drives the sources and consumes the stream.
interface eth_tx_sched_if;
   logic [1:0]  pkt_type;
   logic [31:0] tpa;
   logic [31:0] self_ip;
   logic        arp_start;
   logic [7:0]  arp_dat;
   logic        arp_vld;
   logic        arp_last;
   logic        udp_req;
   logic        udp_gnt;
   logic [7:0]  udp_dat;
   logic        udp_vld;
   logic        udp_last;
   logic [7:0]  tx_dat;
   logic        tx_vld;
   logic        tx_sof;
   logic        tx_eof;
   logic        tx_abort;
   logic        busy;
   logic [7:0]  arp_drop;

   modport slave (
      input  pkt_type, tpa, self_ip,
      output arp_start,
      input  arp_dat, arp_vld, arp_last,
      input  udp_req,
      output udp_gnt,
      input  udp_dat, udp_vld, udp_last,
      output tx_dat, tx_vld, tx_sof, tx_eof, tx_abort, busy, arp_drop
   );

   modport master (
      output pkt_type, tpa, self_ip,
      input  arp_start,
      output arp_dat, arp_vld, arp_last,
      output udp_req,
      input  udp_gnt,
      output udp_dat, udp_vld, udp_last,
      input  tx_dat, tx_vld, tx_sof, tx_eof, tx_abort, busy, arp_drop
   );
endinterface

// File: rtl/eth_tx_sched.sv
// Single TX byte stream scheduler: latches ARP requests for our IP, round-robins ARP/UDP, forwards bytes, forces IFG.
// Latency: 1 clk arbitration, 1 clk byte forwarding. No backpressure: a started/granted source streams freely.
module eth_tx_sched #(
   parameter int unsigned IFG_BYTES = 12,
   parameter int unsigned MAX_FRAME = 1514
) (
   input logic           clk,
   input logic           rst,
   eth_tx_sched_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ARP_TX, UDP_TX, GAP} state_t;

   localparam int unsigned   GW       = (IFG_BYTES > 1) ? $clog2(IFG_BYTES) : 1;
   localparam logic [GW-1:0] IFG_LAST = GW'(IFG_BYTES - 1);
   localparam logic [10:0]   MAX_LAST = 11'(MAX_FRAME - 1);
   localparam logic          SRV_ARP  = 1'b0;
   localparam logic          SRV_UDP  = 1'b1;

   state_t        state_q;
   logic          arp_pend_q, arp_pend_d;
   logic [7:0]    arp_drop_q, arp_drop_d;
   logic          last_srv_q;
   logic [10:0]   byte_cnt_q;
   logic [GW-1:0] gap_cnt_q;
   logic          arp_start_q, udp_gnt_q;
   logic [7:0]    data_q;
   logic          data_vl_q, sof_q, eof_q, abort_q;

   logic       arp_hit, grant_arp, grant_udp, wd_hit;
   logic       src_vl, src_last;
   logic [7:0] src_data;

   always_comb begin
      src_vl   = 1'b0;
      src_last = 1'b0;
      src_data = 8'd0;
      if (state_q == ARP_TX) begin
         src_vl   = bus.arp_vld;
         src_last = bus.arp_last;
         src_data = bus.arp_vld ? bus.arp_dat : 8'd0;
      end else if (state_q == UDP_TX) begin
         src_vl   = bus.udp_vld;
         src_last = bus.udp_last;
         src_data = bus.udp_vld ? bus.udp_dat : 8'd0;
      end
   end

   assign arp_hit   = (bus.pkt_type == 2'd1) && (bus.tpa == bus.self_ip);
   // On contention the source not served last time wins.
   assign grant_arp = (state_q == IDLE) && arp_pend_q && (!bus.udp_req || last_srv_q == SRV_UDP);
   assign grant_udp = (state_q == IDLE) && bus.udp_req && (!arp_pend_q || last_srv_q == SRV_ARP);
   assign wd_hit    = (byte_cnt_q == MAX_LAST);

   // A new request in the same clk as the start pulse keeps the pending flag set.
   assign arp_pend_d = arp_hit | (arp_pend_q & ~grant_arp);
   assign arp_drop_d = (arp_hit && arp_pend_q && !grant_arp && arp_drop_q != 8'hFF)
                       ? arp_drop_q + 8'd1 : arp_drop_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         arp_pend_q  <= 1'b0;
         arp_drop_q  <= 8'd0;
         last_srv_q  <= SRV_UDP;
         byte_cnt_q  <= 11'd0;
         gap_cnt_q   <= '0;
         arp_start_q <= 1'b0;
         udp_gnt_q   <= 1'b0;
         data_q      <= 8'd0;
         data_vl_q   <= 1'b0;
         sof_q       <= 1'b0;
         eof_q       <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         arp_pend_q  <= arp_pend_d;
         arp_drop_q  <= arp_drop_d;
         arp_start_q <= 1'b0;
         udp_gnt_q   <= 1'b0;
         data_q      <= 8'd0;
         data_vl_q   <= 1'b0;
         sof_q       <= 1'b0;
         eof_q       <= 1'b0;
         abort_q     <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_arp) begin
                  state_q     <= ARP_TX;
                  arp_start_q <= 1'b1;
                  byte_cnt_q  <= 11'd0;
               end else if (grant_udp) begin
                  state_q    <= UDP_TX;
                  udp_gnt_q  <= 1'b1;
                  byte_cnt_q <= 11'd0;
               end
            end
            ARP_TX, UDP_TX: begin
               data_q    <= src_data;
               data_vl_q <= src_vl;
               if (src_vl) begin
                  byte_cnt_q <= byte_cnt_q + 11'd1;
                  sof_q      <= (byte_cnt_q == 11'd0);
                  if (src_last || wd_hit) begin
                     eof_q      <= 1'b1;
                     abort_q    <= !src_last;
                     state_q    <= GAP;
                     gap_cnt_q  <= '0;
                     last_srv_q <= (state_q == UDP_TX) ? SRV_UDP : SRV_ARP;
                  end
               end
            end
            GAP: begin
               if (gap_cnt_q == IFG_LAST) state_q <= IDLE;
               else gap_cnt_q <= gap_cnt_q + 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.arp_start = arp_start_q;
   assign bus.udp_gnt   = udp_gnt_q;
   assign bus.tx_dat    = data_q;
   assign bus.tx_vld    = data_vl_q;
   assign bus.tx_sof    = sof_q;
   assign bus.tx_eof    = eof_q;
   assign bus.tx_abort  = abort_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.arp_drop  = arp_drop_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Bench for eth_tx_sched: directed steps with random payloads, expected frames built from bytes sent and the frame rules.
module tb_eth_tx_sched;
   localparam int IFG  = 12;
   localparam int MAXF = 1514;

   logic        clk;
   logic        rst;
   logic [31:0] self_ip;
   eth_tx_sched_if bus();

   eth_tx_sched #(.IFG_BYTES(IFG), .MAX_FRAME(MAXF)) dut (.clk(clk), .rst(rst), .bus(bus));

   int vectors = 0;
   int miscompares = 0;

   int cyc = 0, n_start = 0, n_gnt = 0, n_eof = 0, n_abort = 0, n_stray = 0;
   int gnt_cyc = 0, eof_cyc = 0, idle_run = 0, pre_sof_idle = 0;
   logic [10:0] obs_q[$];

   int          obs_base = 0;
   logic [10:0] exp_q[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      cyc++;
      if (bus.arp_start) n_start++;
      if (bus.udp_gnt) begin
         n_gnt++;
         gnt_cyc = cyc;
      end
      if (bus.tx_vld) begin
         if (bus.tx_sof) pre_sof_idle = idle_run;
         idle_run = 0;
         obs_q.push_back({bus.tx_sof, bus.tx_eof, bus.tx_abort, bus.tx_dat});
      end else begin
         idle_run++;
         if (bus.tx_dat != 8'd0 || bus.tx_sof || bus.tx_eof || bus.tx_abort) n_stray++;
      end
      if (bus.tx_eof) begin
         n_eof++;
         eof_cyc = cyc;
      end
      if (bus.tx_abort) n_abort++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_srcs();
      bus.arp_vld = 1'b0; bus.arp_dat = 8'd0; bus.arp_last = 1'b0;
      bus.udp_vld = 1'b0; bus.udp_dat = 8'd0; bus.udp_last = 1'b0;
   endtask

   // The source not being served carries random junk that must be ignored.
   task automatic drive_src(input bit is_udp, input logic vl, input logic [7:0] d, input logic last);
      if (is_udp) begin
         bus.udp_vld = vl; bus.udp_dat = d; bus.udp_last = last;
         bus.arp_vld = 1'($urandom); bus.arp_dat = 8'($urandom); bus.arp_last = 1'($urandom);
      end else begin
         bus.arp_vld = vl; bus.arp_dat = d; bus.arp_last = last;
         bus.udp_vld = 1'($urandom); bus.udp_dat = 8'($urandom); bus.udp_last = 1'($urandom);
      end
   endtask

   task automatic stream(input bit is_udp, input int n, input bit with_last, input int n_req);
      bit         trunc;
      int         end_idx;
      int         reqs;
      logic [7:0] b;
      logic       e;
      trunc   = (n > MAXF) || (!with_last && n == MAXF);
      end_idx = trunc ? MAXF - 1 : n - 1;
      reqs    = n_req;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(3) == 0) begin
            drive_src(is_udp, 1'b0, 8'd0, 1'b0);
            @(posedge clk); #1;
         end
         b = 8'($urandom);
         drive_src(is_udp, 1'b1, b, with_last && (i == n - 1));
         if (reqs > 0) begin
            bus.pkt_type = 2'd1;
            bus.tpa      = self_ip;
            reqs--;
         end
         if (i < MAXF) begin
            e = (i == end_idx) && (with_last || trunc);
            exp_q.push_back({i == 0, e, e && trunc, b});
         end
         @(posedge clk); #1;
         bus.pkt_type = 2'd0;
      end
      idle_srcs();
   endtask

   task automatic check_frame(input string tag);
      @(posedge clk); #1;
      check({tag, "_len"}, obs_q.size() - obs_base, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (obs_base + i < obs_q.size())
            check(tag, {21'd0, obs_q[obs_base + i]}, {21'd0, exp_q[i]});
      obs_base = obs_q.size();
      exp_q.delete();
   endtask

   task automatic wait_arp_start(input string tag);
      int k = 0;
      while (bus.arp_start !== 1'b1 && k < 3000) begin
         @(posedge clk); #1;
         k++;
      end
      check(tag, bus.arp_start, 1);
   endtask

   task automatic wait_udp_gnt(input string tag);
      int k = 0;
      bus.udp_req = 1'b1;
      while (bus.udp_gnt !== 1'b1 && k < 3000) begin
         @(posedge clk); #1;
         k++;
      end
      bus.udp_req = 1'b0;
      check(tag, bus.udp_gnt, 1);
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (bus.busy !== 1'b0 && k < 3000) begin
         @(posedge clk); #1;
         k++;
      end
      check(tag, bus.busy, 0);
   endtask

   task automatic arp_req_pulse();
      bus.pkt_type = 2'd1;
      bus.tpa      = self_ip;
      @(posedge clk); #1;
      bus.pkt_type = 2'd0;
   endtask

   initial begin
      int s0, e0, a0, g0, exp_drop;
      rst          = 1'b1;
      self_ip      = $urandom;
      bus.self_ip  = self_ip;
      bus.pkt_type = 2'd0;
      bus.tpa      = 32'd0;
      bus.udp_req  = 1'b0;
      idle_srcs();
      exp_drop     = 0;
      #12;
      check("rst_vld", bus.tx_vld, 0);
      check("rst_dat", bus.tx_dat, 0);
      check("rst_sof", bus.tx_sof, 0);
      check("rst_eof", bus.tx_eof, 0);
      check("rst_abort", bus.tx_abort, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_arp_start", bus.arp_start, 0);
      check("rst_udp_gnt", bus.udp_gnt, 0);
      check("rst_drop", bus.arp_drop, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Requests for another IP and non-request types are ignored.
      s0 = n_start;
      bus.pkt_type = 2'd1; bus.tpa = self_ip ^ (32'd1 << $urandom_range(31));
      @(posedge clk); #1;
      bus.pkt_type = 2'd2; bus.tpa = self_ip;
      @(posedge clk); #1;
      bus.pkt_type = 2'd3;
      @(posedge clk); #1;
      bus.pkt_type = 2'd0;
      repeat (4) @(posedge clk);
      #1;
      check("ign_start", n_start - s0, 0);
      check("ign_busy", bus.busy, 0);
      check("ign_drop", bus.arp_drop, 0);

      // ARP and UDP contend with last served = UDP: ARP first, UDP exactly IFG+1 after eof.
      arp_req_pulse();
      bus.udp_req = 1'b1;
      wait_arp_start("t3_arp_first");
      check("t3_no_gnt", bus.udp_gnt, 0);
      stream(1'b0, 42 + int'($urandom_range(20)), 1'b1, 0);
      check_frame("t3_arp_frame");
      wait_udp_gnt("t3_udp_gnt");
      #5;
      check("t3_spacing", gnt_cyc - eof_cyc, IFG + 1);
      stream(1'b1, 60 + int'($urandom_range(40)), 1'b1, 0);
      check_frame("t3_udp_frame");
      check("t3_ifg_idle", pre_sof_idle >= IFG + 1, 1);
      wait_idle("t3_idle");

      // Lone ARP request: start one clk after latching, 42-byte frame, exact IFG.
      s0 = n_start;
      arp_req_pulse();
      check("t1_latched_no_start", bus.arp_start, 0);
      @(posedge clk); #1;
      check("t1_start", bus.arp_start, 1);
      check("t1_busy", bus.busy, 1);
      stream(1'b0, 42, 1'b1, 0);
      check_frame("t1_frame");
      check("t1_one_start", n_start - s0, 1);
      repeat (IFG - 2) @(posedge clk);
      #1;
      check("t1_gap_busy", bus.busy, 1);
      @(posedge clk); #1;
      check("t1_gap_done", bus.busy, 0);

      // Contention with last served = ARP: UDP goes first this time.
      arp_req_pulse();
      bus.udp_req = 1'b1;
      wait_udp_gnt("rr_udp_first");
      check("rr_no_arp_start", bus.arp_start, 0);
      stream(1'b1, 50, 1'b1, 0);
      check_frame("rr_udp_frame");
      wait_arp_start("rr_arp_second");
      stream(1'b0, 42, 1'b1, 0);
      check_frame("rr_arp_frame");

      // Requests during ARP_TX: one stays pending, the rest count as drops (saturating).
      arp_req_pulse();
      wait_arp_start("t4_start");
      stream(1'b0, 42, 1'b1, 3);
      check_frame("t4_frame_a");
      exp_drop = (exp_drop + 3 - 1 > 255) ? 255 : exp_drop + 3 - 1;
      check("t4_drop2", bus.arp_drop, exp_drop);
      wait_arp_start("t4_pend_served");
      stream(1'b0, 320, 1'b1, 300);
      check_frame("t4_frame_b");
      exp_drop = (exp_drop + 300 - 1 > 255) ? 255 : exp_drop + 300 - 1;
      check("t4_drop_sat", bus.arp_drop, exp_drop);
      wait_arp_start("t4_pend_again");
      stream(1'b0, 42, 1'b1, 0);
      check_frame("t4_frame_c");
      check("t4_drop_hold", bus.arp_drop, exp_drop);

      // Watchdog: 1600 bytes without last, only MAXF forwarded, abort+eof on the final one.
      a0 = n_abort;
      g0 = n_gnt;
      wait_udp_gnt("t5_gnt");
      stream(1'b1, 1600, 1'b0, 0);
      check_frame("t5_frame");
      check("t5_abort_once", n_abort - a0, 1);
      check("t5_one_gnt", n_gnt - g0, 1);
      wait_idle("t5_idle");

      // Reset mid-frame: outputs clear at once, no eof, fresh grant works.
      wait_udp_gnt("t6_gnt");
      stream(1'b1, 20, 1'b0, 0);
      e0  = n_eof;
      rst = 1'b1;
      #1;
      check("t6_vld", bus.tx_vld, 0);
      check("t6_busy", bus.busy, 0);
      check("t6_drop", bus.arp_drop, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("t6_no_eof", n_eof - e0, 0);
      obs_base = obs_q.size();
      exp_q.delete();
      wait_udp_gnt("t6_regrant");
      stream(1'b1, 64, 1'b1, 0);
      check_frame("t6_frame");

      check("no_data_when_idle", n_stray, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
